// File: rtl/multi_cycle_adder_if.sv
// Operand/result bundle for multi_cycle_adder.
// ovf is present only with MULTI_CYCLE_ADDER_OVF_EN.
interface multi_cycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, A, B, cin,
    input  busy, done, sum, cout
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, A, B, cin,
    output busy, done, sum, cout
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/multi_cycle_adder.sv
// Multi-cycle add/sub: one SLICE-bit ripple slice per clock.
// Optional signed overflow output: MULTI_CYCLE_ADDER_OVF_EN.
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  multi_cycle_adder_if.slave  bus
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] LAST = KW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_d;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE:0]   sl;
  logic             msb_cin;
  logic             accept;
  int unsigned      base;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = 1'b0;

    base = int'(k_q) * SLICE;
    a_s  = opa_q[base +: SLICE];
    b_s  = opb_q[base +: SLICE];
    sl   = {1'b0, a_s} + {1'b0, b_s}
         + {{SLICE{1'b0}}, carry_q};
    // Carry into the slice MSB, recovered from its sum bit.
    msb_cin = sl[SLICE-1] ^ a_s[SLICE-1]
            ^ b_s[SLICE-1];

    accept = (state_q != RUN) && bus.start;

    unique case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        busy_d = 1'b1;
        res_d[base +: SLICE] = sl[SLICE-1:0];
        carry_d = sl[SLICE];
        if (k_q == LAST) begin
          sum_d   = res_d;
          cout_d  = sl[SLICE];
          ovf_d   = msb_cin ^ sl[SLICE];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      opa_d   = bus.A;
      opb_d   = bus.sub ? ~bus.B : bus.B;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      k_d     = '0;
      busy_d  = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef MULTI_CYCLE_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_n;

  assign ovf_n = done_d ? ovf_d : ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_n;
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed self-checking bench for multi_cycle_adder.
// Checks ovf too when MULTI_CYCLE_ADDER_OVF_EN is defined.
module tb_multi_cycle_adder;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  multi_cycle_adder_if #(.WIDTH(16)) bif ();

  multi_cycle_adder #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic s,
                          input logic c);
    @(negedge clk);
    bif.A = a;
    bif.B = b;
    bif.sub = s;
    bif.cin = c;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  // Waits at negedges for done; reports cycles and busy/done overlap.
  task automatic wait_done(output int cyc,
                           output int busy_cnt,
                           output bit overlap);
    cyc = 0;
    busy_cnt = 0;
    overlap = 1'b0;
    if (bif.busy) busy_cnt++;
    while (!bif.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bif.busy) busy_cnt++;
      if (bif.busy && bif.done) overlap = 1'b1;
    end
  endtask

  task automatic test_reset_initial();
    tests++;
    if ({bif.sum, bif.cout, bif.busy, bif.done}
        !== 19'h0) begin
      fails++;
      $display("FAIL reset_init: sum=%h cout=%b busy=%b done=%b want 0",
               bif.sum, bif.cout, bif.busy, bif.done);
    end
  endtask

  task automatic test_add();
    int cyc, bc;
    bit ov;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    bif.A = 16'hAAAA;
    bif.B = 16'h0F0F;
    bif.cin = 1'b1;
    tests++;
    if (bif.busy !== 1'b1) begin
      fails++;
      $display("FAIL add_busy: got %b want 1", bif.busy);
    end
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc != 4 || bc != 4 || ov) begin
      fails++;
      $display("FAIL add_timing: cyc=%0d busy=%0d ovl=%b want 4 4 0",
               cyc, bc, ov);
    end
    tests++;
    if (bif.sum !== 16'h5555 || bif.cout !== 1'b0) begin
      fails++;
      $display("FAIL add_result: sum=%h cout=%b want 5555 0",
               bif.sum, bif.cout);
    end
    @(negedge clk);
    tests++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0
        || bif.sum !== 16'h5555) begin
      fails++;
      $display("FAIL add_after: done=%b busy=%b sum=%h want 0 0 5555",
               bif.done, bif.busy, bif.sum);
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bif.sum, bif.cout, bif.busy, bif.done}
        !== 19'h0) begin
      fails++;
      $display("FAIL reset_async: sum=%h cout=%b busy=%b done=%b want 0",
               bif.sum, bif.cout, bif.busy, bif.done);
    end
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    tests++;
    if (bif.ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b want 0", bif.ovf);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_op(input string nm,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input logic s,
                          input logic c,
                          input logic [15:0] esum,
                          input logic ecout,
                          input logic eovf);
    int cyc, bc;
    bit ov;
    start_op(a, b, s, c);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc != 4 || bif.sum !== esum
        || bif.cout !== ecout) begin
      fails++;
      $display("FAIL %s: cyc=%0d sum=%h cout=%b want 4 %h %b",
               nm, cyc, bif.sum, bif.cout, esum, ecout);
    end
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    tests++;
    if (bif.ovf !== eovf) begin
      fails++;
      $display("FAIL %s_ovf: got %b want %b", nm, bif.ovf, eovf);
    end
`else
    if (eovf === 1'bx) $display("note: ovf unknown");
`endif
  endtask

  task automatic test_carry();
    check_op("carry_wrap", 16'hFFFF, 16'h0001,
             1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_op("carry_ovf", 16'h7FFF, 16'h0000,
             1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    check_op("sub_borrow", 16'h0005, 16'h0007,
             1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check_op("sub_ovf", 16'h8000, 16'h0001,
             1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_ignore_start();
    int cyc, bc;
    bit ov;
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    bif.A = 16'hFFFF;
    bif.B = 16'hFFFF;
    bif.sub = 1'b1;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc != 3 || bif.sum !== 16'h0003
        || bif.cout !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start: cyc=%0d sum=%h cout=%b want 3 0003 0",
               cyc, bif.sum, bif.cout);
    end
    @(negedge clk);
    tests++;
    if (bif.busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: busy=%b want 0", bif.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    bit ov;
    bit held;
    start_op(16'h0010, 16'h0020, 1'b0, 1'b0);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc != 4 || bif.sum !== 16'h0030) begin
      fails++;
      $display("FAIL b2b_first: cyc=%0d sum=%h want 4 0030",
               cyc, bif.sum);
    end
    bif.A = 16'h0100;
    bif.B = 16'h0200;
    bif.sub = 1'b0;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    cyc = 1;
    held = 1'b1;
    while (!bif.done && cyc < 20) begin
      if (bif.sum !== 16'h0030 || !bif.busy) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != 5 || !held) begin
      fails++;
      $display("FAIL b2b_spacing: cyc=%0d held=%b want 5 1",
               cyc, held);
    end
    tests++;
    if (bif.sum !== 16'h0300 || bif.cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_result: sum=%h cout=%b want 0300 0",
               bif.sum, bif.cout);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    bit ov;
    bit saw_done;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if (bif.sum !== 16'h0000 || bif.busy !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: sum=%h busy=%b want 0000 0",
               bif.sum, bif.busy);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      if (bif.done) saw_done = 1'b1;
    end
    tests++;
    if (saw_done || bif.sum !== 16'h0000) begin
      fails++;
      $display("FAIL midrun_nodone: done_seen=%b sum=%h want 0 0000",
               saw_done, bif.sum);
    end
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc != 4 || bif.sum !== 16'h0002) begin
      fails++;
      $display("FAIL midrun_restart: cyc=%0d sum=%h want 4 0002",
               cyc, bif.sum);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bif.start = 1'b0;
    bif.sub = 1'b0;
    bif.cin = 1'b0;
    bif.A = '0;
    bif.B = '0;
    reset_n = 1'b0;
    #1;
    test_reset_initial();
    #12;
    reset_n = 1'b1;
    test_add();
    test_reset();
    test_carry();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
